alu_unit: RTL
=============

Name: alu_unit

Overview:
- Execution unit on the consumer side of the reservation-station issue interface.
- Accepts one issued op per cycle (rs_ready/rs_op/rs_val1/rs_val2/rs_id).
- Computes the result and broadcasts it on alu_ready/alu_res/alu_id, which feeds the RS wakeup logic and the ROB.
- Optionally uses a serial shifter, with a one-entry skid slot and busy backpressure toward the RS.

Parameters:
- XLEN, 32, datapath width (global define).
- ALU_OP_WIDTH, per global_params.v, op-code width (global define).
- ROB_SIZE_WIDTH, per global_params.v, ROB id width (global define).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  branch-mispredict flush
- rs_ready  in  1  issue valid
- rs_op  in  ALU_OP_WIDTH  ALU op code
- rs_val1  in  XLEN  operand 1
- rs_val2  in  XLEN  operand 2
- rs_id  in  ROB_SIZE_WIDTH  ROB id of the op
- alu_ready  out  1  result valid (one-cycle pulse per op)
- alu_res  out  XLEN  result
- alu_id  out  ROB_SIZE_WIDTH  ROB id of the result
- alu_busy  out  1  RS must not issue when it samples this high

Behaviour:
- Reset and flush have the same effect and rst has priority. Next cycle: alu_ready=0, alu_res=0, alu_id=0, state=IDLE, skid empty, alu_busy=0. An rs_ready in the same cycle as rst/flush is dropped.
- Ops, all producing XLEN results:
  - ALU_ADD, ALU_SUB: wrap modulo 2^XLEN.
  - ALU_AND, ALU_OR, ALU_XOR: bitwise.
  - ALU_SHL, ALU_SHR, ALU_SHRA: shift amount is rs_val2[4:0]; SHRA fills with sign.
  - ALU_EQ, ALU_NEQ, ALU_LT, ALU_GE: signed compares where applicable; result 1 or 0.
  - ALU_LTU, ALU_GEU: unsigned compares; result 1 or 0.
  - Undefined op: result 0, alu_ready still pulses.
- Single-cycle path: op accepted at edge T. In the cycle after T: alu_ready=1, alu_res=result, alu_id=rs_id. Throughput is one op per cycle; back-to-back issues give back-to-back pulses.
- alu_ready is exactly one cycle per op. With no op completing, alu_ready=0 and alu_res/alu_id hold their last values.
- Result order equals issue order; no reordering.
- Without ALU_SERIAL_SHIFT_EN: alu_busy is tied 0, no FSM, no skid slot.

Optional Feature:
- Macro: ALU_SERIAL_SHIFT_EN.
- Defined: shifts use an iterative 1-bit-per-cycle shifter.
  - FSM states: IDLE, SHIFT. Registers: acc, cnt[4:0], shift kind, id.
  - Shift with shamt=0 takes the single-cycle path.
  - Shift with shamt=n>0 accepted at edge T: state=SHIFT, acc=val1, cnt=n.
  - Each edge in SHIFT shifts acc by 1 and decrements cnt.
  - The edge where cnt goes to 0 returns to IDLE and pulses alu_ready in the next cycle. Latency is n cycles from acceptance.
  - alu_busy = (state==SHIFT) | skid_valid, combinational.
  - The RS issue is registered, so one op can arrive in the cycle after a shift is accepted. That op is captured in the skid slot.
  - The skid op executes in the cycle after the shift result pulses. It may itself be a shift, which re-enters SHIFT.
  - rs_ready arriving while the skid slot is full is a protocol violation: flagged by a simulation assertion, op dropped.
  - flush mid-shift: abort, no alu_ready for the aborted shift, skid cleared.
- Undefined: every op takes the single-cycle path, alu_busy=0.

Test Plan:
- ADD 0x7FFFFFFF + 1, id=3 -> next cycle alu_ready=1, alu_res=0x80000000, alu_id=3; then alu_ready=0.
- Back-to-back: SUB 5-7 (id1), LT -1<1 (id2), LTU 0xFFFFFFFF<1 (id3) -> three consecutive pulses: 0xFFFFFFFE/id1, 1/id2, 0/id3.
- SHRA 0x80000000 by 4, id=6 -> 0xF8000000/id6. With ALU_SERIAL_SHIFT_EN: alu_busy=1 during the 4-cycle shift, result 4 cycles after acceptance.
- With ALU_SERIAL_SHIFT_EN: SHL 1 by 3 (id1), then ADD 2+2 (id2) one cycle later -> ADD held in skid; pulses 8/id1, then 4/id2 on the next cycle; alu_busy falls after the skid drains.
- Flush during the 2nd cycle of a SHL-by-10 with an ADD in skid -> no further alu_ready, alu_busy=0 next cycle, new ADD 1+1 (id4) -> 2/id4.
- rst asserted together with rs_ready (ADD 1+1) -> no alu_ready; alu_res=0, alu_id=0.

Source files
------------

// File: rtl/alu_unit_if.sv
// Issue/result interface between the reservation station and alu_unit, plus the
// global width and op-code defines shared by both sides.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_AND  4'd2
`define ALU_OR   4'd3
`define ALU_XOR  4'd4
`define ALU_SHL  4'd5
`define ALU_SHR  4'd6
`define ALU_SHRA 4'd7
`define ALU_EQ   4'd8
`define ALU_NEQ  4'd9
`define ALU_LT   4'd10
`define ALU_GE   4'd11
`define ALU_LTU  4'd12
`define ALU_GEU  4'd13
`endif

interface alu_unit_if;
  logic                       rs_ready;
  logic [`ALU_OP_WIDTH-1:0]   rs_op;
  logic [`XLEN-1:0]           rs_val1;
  logic [`XLEN-1:0]           rs_val2;
  logic [`ROB_SIZE_WIDTH-1:0] rs_id;
  logic                       alu_ready;
  logic [`XLEN-1:0]           alu_res;
  logic [`ROB_SIZE_WIDTH-1:0] alu_id;
  logic                       alu_busy;

  modport master (
    output rs_ready, rs_op, rs_val1, rs_val2, rs_id,
    input  alu_ready, alu_res, alu_id, alu_busy
  );

  modport slave (
    input  rs_ready, rs_op, rs_val1, rs_val2, rs_id,
    output alu_ready, alu_res, alu_id, alu_busy
  );
endinterface

// File: rtl/alu_unit.sv
// Execution unit consuming RS issues and broadcasting results to wakeup/ROB.
// Define ALU_SERIAL_SHIFT_EN for a 1-bit-per-cycle shifter with a one-entry skid slot.
module alu_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  alu_unit_if.slave  bus
);
  localparam int XW = `XLEN;
  localparam int OW = `ALU_OP_WIDTH;
  localparam int IW = `ROB_SIZE_WIDTH;

  function automatic logic [XW-1:0] alu_compute(input logic [OW-1:0] op,
                                                input logic [XW-1:0] a,
                                                input logic [XW-1:0] b);
    logic [XW-1:0] r;
    logic [4:0]    shamt;
    shamt = b[4:0];
    case (op)
      `ALU_ADD:  r = a + b;
      `ALU_SUB:  r = a - b;
      `ALU_AND:  r = a & b;
      `ALU_OR:   r = a | b;
      `ALU_XOR:  r = a ^ b;
      `ALU_SHL:  r = a << shamt;
      `ALU_SHR:  r = a >> shamt;
      `ALU_SHRA: r = $unsigned($signed(a) >>> shamt);
      `ALU_EQ:   r = {{(XW-1){1'b0}}, (a == b)};
      `ALU_NEQ:  r = {{(XW-1){1'b0}}, (a != b)};
      `ALU_LT:   r = {{(XW-1){1'b0}}, ($signed(a) < $signed(b))};
      `ALU_GE:   r = {{(XW-1){1'b0}}, ($signed(a) >= $signed(b))};
      `ALU_LTU:  r = {{(XW-1){1'b0}}, (a < b)};
      `ALU_GEU:  r = {{(XW-1){1'b0}}, (a >= b)};
      default:   r = '0;
    endcase
    return r;
  endfunction

  logic          rdy_q, rdy_d;
  logic [XW-1:0] res_q, res_d;
  logic [IW-1:0] id_q,  id_d;

  assign bus.alu_ready = rdy_q;
  assign bus.alu_res   = res_q;
  assign bus.alu_id    = id_q;

`ifdef ALU_SERIAL_SHIFT_EN
  typedef enum logic {IDLE, SHIFT} state_e;

  function automatic logic is_shift(input logic [OW-1:0] op);
    return (op == `ALU_SHL) || (op == `ALU_SHR) || (op == `ALU_SHRA);
  endfunction

  function automatic logic [XW-1:0] shift_step(input logic [OW-1:0] kind,
                                               input logic [XW-1:0] v);
    logic [XW-1:0] r;
    case (kind)
      `ALU_SHL:  r = {v[XW-2:0], 1'b0};
      `ALU_SHRA: r = {v[XW-1], v[XW-1:1]};
      default:   r = {1'b0, v[XW-1:1]};
    endcase
    return r;
  endfunction

  state_e        state_q, state_d;
  logic [XW-1:0] acc_q, acc_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [OW-1:0] kind_q, kind_d;
  logic [IW-1:0] sid_q, sid_d;
  logic          skid_valid_q, skid_valid_d;
  logic [OW-1:0] skid_op_q, skid_op_d;
  logic [XW-1:0] skid_v1_q, skid_v1_d;
  logic [XW-1:0] skid_v2_q, skid_v2_d;
  logic [IW-1:0] skid_id_q, skid_id_d;

  logic          ex_valid;
  logic [OW-1:0] ex_op;
  logic [XW-1:0] ex_v1, ex_v2;
  logic [IW-1:0] ex_id;

  assign bus.alu_busy = (state_q == SHIFT) | skid_valid_q;

  // A pending skid op always goes ahead of a new issue so results stay in issue order.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    kind_d       = kind_q;
    sid_d        = sid_q;
    skid_valid_d = skid_valid_q;
    skid_op_d    = skid_op_q;
    skid_v1_d    = skid_v1_q;
    skid_v2_d    = skid_v2_q;
    skid_id_d    = skid_id_q;
    rdy_d        = 1'b0;
    res_d        = res_q;
    id_d         = id_q;
    ex_valid     = 1'b0;
    ex_op        = bus.rs_op;
    ex_v1        = bus.rs_val1;
    ex_v2        = bus.rs_val2;
    ex_id        = bus.rs_id;

    case (state_q)
      IDLE: begin
        if (skid_valid_q) begin
          ex_valid     = 1'b1;
          ex_op        = skid_op_q;
          ex_v1        = skid_v1_q;
          ex_v2        = skid_v2_q;
          ex_id        = skid_id_q;
          skid_valid_d = 1'b0;
        end else if (bus.rs_ready) begin
          ex_valid = 1'b1;
        end
      end
      SHIFT: begin
        acc_d = shift_step(kind_q, acc_q);
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = IDLE;
          rdy_d   = 1'b1;
          res_d   = shift_step(kind_q, acc_q);
          id_d    = sid_q;
        end
        if (bus.rs_ready && !skid_valid_q) begin
          skid_valid_d = 1'b1;
          skid_op_d    = bus.rs_op;
          skid_v1_d    = bus.rs_val1;
          skid_v2_d    = bus.rs_val2;
          skid_id_d    = bus.rs_id;
        end
      end
      default: state_d = IDLE;
    endcase

    if (ex_valid) begin
      if (is_shift(ex_op) && (ex_v2[4:0] != 5'd0)) begin
        state_d = SHIFT;
        acc_d   = ex_v1;
        cnt_d   = ex_v2[4:0];
        kind_d  = ex_op;
        sid_d   = ex_id;
      end else begin
        rdy_d = 1'b1;
        res_d = alu_compute(ex_op, ex_v1, ex_v2);
        id_d  = ex_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rdy_q        <= 1'b0;
      res_q        <= '0;
      id_q         <= '0;
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      kind_q       <= '0;
      sid_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_op_q    <= '0;
      skid_v1_q    <= '0;
      skid_v2_q    <= '0;
      skid_id_q    <= '0;
    end else begin
      rdy_q        <= rdy_d;
      res_q        <= res_d;
      id_q         <= id_d;
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      kind_q       <= kind_d;
      sid_q        <= sid_d;
      skid_valid_q <= skid_valid_d;
      skid_op_q    <= skid_op_d;
      skid_v1_q    <= skid_v1_d;
      skid_v2_q    <= skid_v2_d;
      skid_id_q    <= skid_id_d;
    end
  end

  // The RS may only slip one op past alu_busy; a second one is lost.
  skid_overflow_a: assert property (@(posedge clk) disable iff (rst || flush)
                                    !(bus.rs_ready && skid_valid_q));
`else
  assign bus.alu_busy = 1'b0;

  always_comb begin
    rdy_d = bus.rs_ready;
    res_d = res_q;
    id_d  = id_q;
    if (bus.rs_ready) begin
      res_d = alu_compute(bus.rs_op, bus.rs_val1, bus.rs_val2);
      id_d  = bus.rs_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rdy_q <= 1'b0;
      res_q <= '0;
      id_q  <= '0;
    end else begin
      rdy_q <= rdy_d;
      res_q <= res_d;
      id_q  <= id_d;
    end
  end
`endif
endmodule
